// File: rtl/pkt_fifo_pkg.sv
// Shared helpers for the packet-commit FIFO: pointer width function and drop counter width.
package pkt_fifo_pkg;

    localparam int DROP_CNT_W = 16;

    // One extra MSB over the address lets full and empty be told apart.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pkt_fifo_ram.sv
// Simple dual-port storage: one write port and one read port with a registered output.
// The array is not reset. Only the read data register is cleared by reset.
module pkt_fifo_ram #(
    parameter int EW = 78,
    parameter int AW = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [EW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [EW-1:0] o_rdata
);

    logic [EW-1:0] r_mem [0:(1<<AW)-1];
    logic [EW-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // The read register holds its value between reads.
    always_ff @(posedge i_clk) begin
        if (i_rst)     r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/pkt_commit_fifo.sv
// Packet-aware FIFO: words become readable only when their packet commits on eop.
// Partial packets rewind on abort/overflow. The drop counter exists only with PKT_COMMIT_FIFO_STATS_EN.
module pkt_commit_fifo
    import pkt_fifo_pkg::*;
#(
    parameter int WIDTH     = 77,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 2
) (
    input  logic                    clk_net,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [WIDTH-1:0]        din,
    input  logic                    wr_eop,
    input  logic                    wr_abort,
    output logic                    full,
    output logic                    almost_full,
    input  logic                    rd_en,
    output logic [WIDTH-1:0]        dout,
    output logic                    dout_eop,
    output logic                    dout_valid,
    output logic                    empty,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic [DROP_CNT_W-1:0]   drop_cnt
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;
    localparam int EW = WIDTH + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] AF_P    = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_P    = PW'(AE_THRESH);

    logic [PW-1:0] r_wr_ptr, r_cmt_ptr, r_rd_ptr, r_count;
    logic          r_bad_pkt, r_full, r_empty, r_af, r_ae, r_dout_valid;

    logic [PW-1:0] w_wr_ptr_nxt, w_cmt_ptr_nxt, w_rd_ptr_nxt;
    logic [PW-1:0] w_used_nxt, w_cmt_cnt_nxt;
    logic          w_bad_nxt, w_wr_acc, w_rd_acc;
    logic [EW-1:0] w_rdata;

    assign w_wr_acc = wr_en & ~r_full & ~r_bad_pkt & ~wr_abort;
    assign w_rd_acc = rd_en & ~r_empty;

    always_comb begin
        w_wr_ptr_nxt  = r_wr_ptr;
        w_cmt_ptr_nxt = r_cmt_ptr;
        w_bad_nxt     = r_bad_pkt;
        if (wr_abort) begin
            w_wr_ptr_nxt = r_cmt_ptr;
            w_bad_nxt    = 1'b0;
        end else if (w_wr_acc) begin
            w_wr_ptr_nxt = r_wr_ptr + 1'b1;
            if (wr_eop) w_cmt_ptr_nxt = r_wr_ptr + 1'b1;
        end else if (wr_en) begin
            // Full or already poisoned: drop the word and rewind once the packet ends.
            if (wr_eop) begin
                w_wr_ptr_nxt = r_cmt_ptr;
                w_bad_nxt    = 1'b0;
            end else begin
                w_bad_nxt    = 1'b1;
            end
        end
    end

    assign w_rd_ptr_nxt  = w_rd_acc ? (r_rd_ptr + 1'b1) : r_rd_ptr;
    assign w_used_nxt    = w_wr_ptr_nxt - w_rd_ptr_nxt;
    assign w_cmt_cnt_nxt = w_cmt_ptr_nxt - w_rd_ptr_nxt;

    always_ff @(posedge clk_net) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_cmt_ptr    <= '0;
            r_rd_ptr     <= '0;
            r_bad_pkt    <= 1'b0;
            r_full       <= 1'b0;
            r_af         <= 1'b0;
            r_empty      <= 1'b1;
            r_ae         <= 1'b1;
            r_count      <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_cmt_ptr    <= w_cmt_ptr_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_bad_pkt    <= w_bad_nxt;
            r_full       <= (w_used_nxt == DEPTH_P);
            r_af         <= (w_used_nxt >= AF_P);
            r_empty      <= (w_cmt_cnt_nxt == '0);
            r_ae         <= (w_cmt_cnt_nxt <= AE_P);
            r_count      <= w_cmt_cnt_nxt;
            r_dout_valid <= w_rd_acc;
        end
    end

    pkt_fifo_ram #(
        .EW (EW),
        .AW (AW)
    ) u_ram (
        .i_clk   (clk_net),
        .i_rst   (rst),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata ({wr_eop, din}),
        .i_re    (w_rd_acc),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_rdata)
    );

`ifdef PKT_COMMIT_FIFO_STATS_EN
    logic [DROP_CNT_W-1:0] r_drop_cnt;
    logic                  w_drop_inc;

    // An abort with nothing pending or poisoned is not a drop.
    assign w_drop_inc = wr_abort ? ((r_wr_ptr != r_cmt_ptr) | r_bad_pkt)
                                 : (wr_en & (r_full | r_bad_pkt) & wr_eop);

    always_ff @(posedge clk_net) begin
        if (rst)                              r_drop_cnt <= '0;
        else if (w_drop_inc && ~&r_drop_cnt)  r_drop_cnt <= r_drop_cnt + 1'b1;
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign drop_cnt = '0;
`endif

    assign full         = r_full;
    assign almost_full  = r_af;
    assign empty        = r_empty;
    assign almost_empty = r_ae;
    assign count        = r_count;
    assign dout_valid   = r_dout_valid;
    assign dout         = w_rdata[WIDTH-1:0];
    assign dout_eop     = w_rdata[WIDTH];

endmodule

// File: tb/tb_pkt_commit_fifo.sv
// Self-checking bench for pkt_commit_fifo: vector table, directed corner sequences, random traffic vs queue model.
module tb_pkt_commit_fifo;

    localparam int DEPTH = 16;
`ifdef PKT_COMMIT_FIFO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk_net, rst, wr_en, wr_eop, wr_abort, rd_en;
    logic [76:0] din;
    logic        full, almost_full, dout_eop, dout_valid, empty, almost_empty;
    logic [76:0] dout;
    logic [4:0]  count;
    logic [15:0] drop_cnt;

    pkt_commit_fifo dut (
        .clk_net      (clk_net),
        .rst          (rst),
        .wr_en        (wr_en),
        .din          (din),
        .wr_eop       (wr_eop),
        .wr_abort     (wr_abort),
        .full         (full),
        .almost_full  (almost_full),
        .rd_en        (rd_en),
        .dout         (dout),
        .dout_eop     (dout_eop),
        .dout_valid   (dout_valid),
        .empty        (empty),
        .almost_empty (almost_empty),
        .count        (count),
        .drop_cnt     (drop_cnt)
    );

    initial clk_net = 1'b0;
    always #5 clk_net = ~clk_net;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: committed words, the pending packet, poison flag, drop tally, last read word.
    logic [77:0] q_cmt[$];
    logic [77:0] q_pend[$];
    bit          m_bad;
    int          m_drop;
    logic [76:0] m_dout;
    logic        m_deop;
    logic        m_valid;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_drop(input int d);
        if (!STATS) return 16'd0;
        return (d > 65535) ? 16'hFFFF : 16'(d);
    endfunction

    task automatic model_reset();
        q_cmt.delete();
        q_pend.delete();
        m_bad   = 1'b0;
        m_drop  = 0;
        m_dout  = '0;
        m_deop  = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic model_update(input logic we, input logic [76:0] d, input logic eo,
                                input logic ab, input logic re);
        bit was_full, was_empty;
        logic [77:0] e;
        was_full  = (q_cmt.size() + q_pend.size()) == DEPTH;
        was_empty = (q_cmt.size() == 0);
        m_valid = 1'b0;
        if (re && !was_empty) begin
            e = q_cmt.pop_front();
            m_dout  = e[76:0];
            m_deop  = e[77];
            m_valid = 1'b1;
        end
        if (ab) begin
            if (q_pend.size() != 0 || m_bad) m_drop++;
            q_pend.delete();
            m_bad = 1'b0;
        end else if (we) begin
            if (!was_full && !m_bad) begin
                q_pend.push_back({eo, d});
                if (eo) begin
                    foreach (q_pend[i]) q_cmt.push_back(q_pend[i]);
                    q_pend.delete();
                end
            end else if (eo) begin
                q_pend.delete();
                m_bad = 1'b0;
                m_drop++;
            end else begin
                m_bad = 1'b1;
            end
        end
    endtask

    task automatic check_model();
        int used, cm;
        used = q_cmt.size() + q_pend.size();
        cm   = q_cmt.size();
        chk("full",         128'(full),         128'(used == DEPTH));
        chk("almost_full",  128'(almost_full),  128'(used >= 12));
        chk("empty",        128'(empty),        128'(cm == 0));
        chk("almost_empty", 128'(almost_empty), 128'(cm <= 2));
        chk("count",        128'(count),        128'(cm));
        chk("drop_cnt",     128'(drop_cnt),     128'(exp_drop(m_drop)));
        chk("dout_valid",   128'(dout_valid),   128'(m_valid));
        chk("dout",         128'(dout),         128'(m_dout));
        chk("dout_eop",     128'(dout_eop),     128'(m_deop));
    endtask

    task automatic step(input logic we, input logic [76:0] d, input logic eo,
                        input logic ab, input logic re);
        wr_en = we; din = d; wr_eop = eo; wr_abort = ab; rd_en = re;
        @(posedge clk_net);
        model_update(we, d, eo, ab, re);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_en = 1'b0; wr_eop = 1'b0; wr_abort = 1'b0; rd_en = 1'b0; din = '0;
        @(posedge clk_net);
        model_reset();
        #1;
        check_model();
        rst = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [76:0] d;
        logic        eo;
        logic        ab;
        logic        re;
        logic        x_empty;
        logic [4:0]  x_count;
        logic        x_valid;
        logic [76:0] x_dout;
        logic        x_deop;
        logic [15:0] x_drop;
    } vec_t;

    function automatic vec_t mkv(input logic we, input logic [76:0] d, input logic eo,
                                 input logic ab, input logic re, input logic xe,
                                 input logic [4:0] xc, input logic xv, input logic [76:0] xd,
                                 input logic xdeop, input logic [15:0] xdrop);
        vec_t v;
        v.we = we; v.d = d; v.eo = eo; v.ab = ab; v.re = re;
        v.x_empty = xe; v.x_count = xc; v.x_valid = xv; v.x_dout = xd;
        v.x_deop = xdeop; v.x_drop = xdrop;
        return v;
    endfunction

    localparam logic [76:0] PA = 77'h1_AAAA_0000_1111_2222;
    localparam logic [76:0] PB = 77'h0_BBBB_3333_4444_5555;
    localparam logic [76:0] PC = 77'h1_CCCC_6666_7777_8888;
    localparam logic [76:0] PD = 77'h0_DDDD_9999_AAAA_BBBB;
    localparam logic [76:0] PJ = 77'h1_FFFF_EEEE_DDDD_CCCC;
    localparam logic [76:0] PZ = 77'd0;

    vec_t tbl[13];

    initial begin
        logic [95:0] rnd;
        int rd_pct, wexp, rexp;

        rst = 1'b1; wr_en = 1'b0; wr_eop = 1'b0; wr_abort = 1'b0; rd_en = 1'b0; din = '0;
        model_reset();
        repeat (2) @(posedge clk_net);
        do_reset();

        // Packet A,B,C then read back; abort of a partial packet; packet D.
        tbl[0]  = mkv(1'b1, PA, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, PZ, 1'b0, 16'd0);
        tbl[1]  = mkv(1'b1, PB, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, PZ, 1'b0, 16'd0);
        tbl[2]  = mkv(1'b1, PC, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 1'b0, PZ, 1'b0, 16'd0);
        tbl[3]  = mkv(1'b0, PZ, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 1'b1, PA, 1'b0, 16'd0);
        tbl[4]  = mkv(1'b0, PZ, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1, PB, 1'b0, 16'd0);
        tbl[5]  = mkv(1'b0, PZ, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b1, PC, 1'b1, 16'd0);
        tbl[6]  = mkv(1'b0, PZ, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, PC, 1'b1, 16'd0);
        tbl[7]  = mkv(1'b1, PJ, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, PC, 1'b1, 16'd0);
        tbl[8]  = mkv(1'b1, PJ, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, PC, 1'b1, 16'd0);
        tbl[9]  = mkv(1'b1, PJ, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, PC, 1'b1, 16'd1);
        tbl[10] = mkv(1'b0, PZ, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, PC, 1'b1, 16'd1);
        tbl[11] = mkv(1'b1, PD, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, PC, 1'b1, 16'd1);
        tbl[12] = mkv(1'b0, PZ, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b1, PD, 1'b1, 16'd1);

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].we, tbl[i].d, tbl[i].eo, tbl[i].ab, tbl[i].re);
            chk($sformatf("tbl%0d.empty", i), 128'(empty),      128'(tbl[i].x_empty));
            chk($sformatf("tbl%0d.count", i), 128'(count),      128'(tbl[i].x_count));
            chk($sformatf("tbl%0d.valid", i), 128'(dout_valid), 128'(tbl[i].x_valid));
            chk($sformatf("tbl%0d.dout", i),  128'(dout),       128'(tbl[i].x_dout));
            chk($sformatf("tbl%0d.deop", i),  128'(dout_eop),   128'(tbl[i].x_deop));
            chk($sformatf("tbl%0d.drop", i),  128'(drop_cnt),   128'(STATS ? tbl[i].x_drop : 16'd0));
        end

        // Sixteen single-word packets fill the FIFO; the seventeenth is dropped.
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 77'(i), 1'b1, 1'b0, 1'b0);
        chk("fill.full",  128'(full),  128'(1));
        chk("fill.count", 128'(count), 128'(16));
        step(1'b1, 77'd99, 1'b1, 1'b0, 1'b0);
        chk("ovf.drop",  128'(drop_cnt), 128'(STATS ? 16'd1 : 16'd0));
        chk("ovf.count", 128'(count),    128'(16));
        for (int i = 0; i < 16; i++) begin
            step(1'b0, PZ, 1'b0, 1'b0, 1'b1);
            chk($sformatf("drain%0d", i), 128'(dout), 128'(i));
        end
        chk("drain.empty", 128'(empty), 128'(1));

        // A 20-word packet cannot commit: overflow at word 17, rewind at eop.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 77'(k + 100), (k == 19) ? 1'b1 : 1'b0, 1'b0, 1'b0);
            if (k == 15) chk("long.full_at16", 128'(full), 128'(1));
        end
        chk("long.count", 128'(count),    128'(0));
        chk("long.full",  128'(full),     128'(0));
        chk("long.empty", 128'(empty),    128'(1));
        chk("long.drop",  128'(drop_cnt), 128'(STATS ? 16'd1 : 16'd0));

        // Steady read+write at count=8 for 100 words.
        wexp = 1000; rexp = 1000;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 77'(wexp), 1'b1, 1'b0, 1'b0);
            wexp++;
        end
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 77'(wexp), 1'b1, 1'b0, 1'b1);
            wexp++;
            chk("steady.count", 128'(count), 128'(8));
            chk("steady.dout",  128'(dout),  128'(rexp));
            rexp++;
        end
        chk("steady.drop", 128'(drop_cnt), 128'(STATS ? 16'd1 : 16'd0));
        for (int i = 0; i < 8; i++) step(1'b0, PZ, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a packet with five committed words.
        for (int i = 0; i < 5; i++) step(1'b1, 77'(i + 50), 1'b1, 1'b0, 1'b0);
        step(1'b1, 77'd60, 1'b0, 1'b0, 1'b0);
        step(1'b1, 77'd61, 1'b0, 1'b0, 1'b0);
        chk("pre_rst.count", 128'(count), 128'(5));
        do_reset();
        chk("rst.empty", 128'(empty),    128'(1));
        chk("rst.count", 128'(count),    128'(0));
        chk("rst.dout",  128'(dout),     128'(0));
        chk("rst.drop",  128'(drop_cnt), 128'(0));
        step(1'b0, PZ, 1'b0, 1'b0, 1'b1);
        chk("rst.rd_valid", 128'(dout_valid), 128'(0));
        chk("rst.rd_dout",  128'(dout),       128'(0));

        // Random traffic with read pressure varying per block.
        for (int blk = 0; blk < 12; blk++) begin
            rd_pct = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 50 : 90);
            for (int c = 0; c < 200; c++) begin
                rnd = {$urandom(), $urandom(), $urandom()};
                step(($urandom_range(99) < 70) ? 1'b1 : 1'b0, rnd[76:0],
                     ($urandom_range(99) < 12) ? 1'b1 : 1'b0,
                     ($urandom_range(99) < 2)  ? 1'b1 : 1'b0,
                     ($urandom_range(99) < rd_pct) ? 1'b1 : 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
